// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, serial-out transmitter with optional inter-word gap
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = GAP < 1 ? 1 : $clog2(GAP + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             sout_q, sout_d, sv_q, sv_d, busy_q, busy_d, done_q, done_d;
  logic             last, accept;
  // cnt_q is the index of the bit currently on sout; the last-bit cycle may reload when GAP=0
  assign last      = state_q == S_SHIFT && cnt_q == CW'(WIDTH - 1);
  assign din_ready = !rst && (state_q == S_IDLE || (last && GAP == 0));
  assign accept    = din_valid && din_ready;
  assign sout       = sout_q;
  assign sout_valid = sv_q;
  assign busy       = busy_q;
  assign done       = done_q;
  // next-state: the first bit of an accepted word is presented straight from din
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    sout_d  = 1'b0;
    sv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (accept) begin
      state_d = S_SHIFT;
      shreg_d = din;
      cnt_d   = '0;
      sout_d  = LSB_FIRST != 0 ? din[0] : din[WIDTH-1];
      sv_d    = 1'b1;
      busy_d  = 1'b1;
    end else if (state_q == S_SHIFT && !last) begin
      shreg_d = LSB_FIRST != 0 ? shreg_q >> 1 : shreg_q << 1;
      cnt_d   = cnt_q + 1'b1;
      sout_d  = LSB_FIRST != 0 ? shreg_q[1] : shreg_q[WIDTH-2];
      sv_d    = 1'b1;
      busy_d  = 1'b1;
      done_d  = cnt_q == CW'(WIDTH - 2);
    end else if (last) begin
      state_d = GAP > 0 ? S_GAP : S_IDLE;
      gcnt_d  = '0;
      busy_d  = GAP > 0;
    end else if (state_q == S_GAP) begin
      state_d = gcnt_q == GW'(GAP - 1) ? S_IDLE : S_GAP;
      gcnt_d  = gcnt_q + 1'b1;
      busy_d  = gcnt_q != GW'(GAP - 1);
    end
  end
  // state and registered outputs; reset discards any word or gap in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      sout_q  <= 1'b0;
      sv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      sout_q  <= sout_d;
      sv_q    <= sv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: three configurations checked against a cycle-queue reference model
module tb_piso_serializer;
  typedef struct packed {logic s; logic v; logic b; logic d;} rec_t;
  typedef struct {logic v; logic [7:0] d; logic s0; logic s1; logic sv; logic dn; logic bz;} vec_t;
  logic clk = 1'b0, rst = 1'b1, din_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] rdy, so, sv, bz, dn;
  int checks = 0, failures = 0;
  int lsb [3] = '{1, 0, 1};
  int gap [3] = '{0, 0, 2};
  rec_t pend [3][$];
  rec_t cur [3];
  vec_t tab [9];
  always #5 clk = ~clk;
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP(0)) u0 (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0]));
  piso_serializer #(.WIDTH(8), .LSB_FIRST(0), .GAP(0)) u1 (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1]));
  piso_serializer #(.WIDTH(8), .LSB_FIRST(1), .GAP(2)) u2 (.clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .din_ready(rdy[2]), .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]), .done(dn[2]));
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  // ready when nothing is queued and the current cycle is idle or a last bit
  function automatic logic exp_ready(int i);
    return !rst && pend[i].size() == 0 && (!cur[i].b || cur[i].d);
  endfunction
  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      pend[i].delete();
      cur[i] = '0;
    end
  endtask
  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d sout", i), 32'(so[i]), 32'(cur[i].s));
      chk($sformatf("u%0d sout_valid", i), 32'(sv[i]), 32'(cur[i].v));
      chk($sformatf("u%0d busy", i), 32'(bz[i]), 32'(cur[i].b));
      chk($sformatf("u%0d done", i), 32'(dn[i]), 32'(cur[i].d));
      chk($sformatf("u%0d din_ready", i), 32'(rdy[i]), 32'(exp_ready(i)));
    end
  endtask
  // one clock: model consumes the inputs seen at the edge, outputs compared mid-cycle
  task automatic tick();
    @(posedge clk);
    if (rst) model_clear();
    else for (int i = 0; i < 3; i++) begin
      if (din_valid && exp_ready(i)) begin
        for (int k = 0; k < 8; k++)
          pend[i].push_back('{s: lsb[i] != 0 ? din[k] : din[7-k], v: 1'b1, b: 1'b1, d: k == 7});
        for (int g = 0; g < gap[i]; g++) pend[i].push_back('{s: 1'b0, v: 1'b0, b: 1'b1, d: 1'b0});
      end
      cur[i] = pend[i].size() != 0 ? pend[i].pop_front() : rec_t'('0);
    end
    @(negedge clk);
    compare_all();
  endtask
  initial begin
    logic [15:0] bb;
    bit seen;
    tab[0] = '{1'b1, 8'hB4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tab[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tab[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tab[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tab[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tab[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tab[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tab[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tab[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    model_clear();
    repeat (3) tick();
    for (int i = 0; i < 3; i++) chk($sformatf("reset u%0d outs", i), {28'(0), rdy[i], sv[i], bz[i], dn[i]}, 32'h0);
    #2 rst = 1'b0;
    tick();
    // single word B4, LSB- and MSB-first side by side
    for (int j = 0; j < 9; j++) begin
      din_valid = tab[j].v;
      din = tab[j].d;
      tick();
      chk($sformatf("tab%0d u0 sout", j), 32'(so[0]), 32'(tab[j].s0));
      chk($sformatf("tab%0d u1 sout", j), 32'(so[1]), 32'(tab[j].s1));
      chk($sformatf("tab%0d u0 valid", j), 32'(sv[0]), 32'(tab[j].sv));
      chk($sformatf("tab%0d u1 done", j), 32'(dn[1]), 32'(tab[j].dn));
      chk($sformatf("tab%0d u0 busy", j), 32'(bz[0]), 32'(tab[j].bz));
    end
    repeat (4) tick();
    // back-to-back F0 then 0F on u0
    bb = 16'b0000111111110000;
    din_valid = 1'b1;
    din = 8'hF0;
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("b2b bit%0d sout", k), 32'(so[0]), 32'(bb[15-k]));
      chk($sformatf("b2b bit%0d valid", k), 32'(sv[0]), 32'h1);
      chk($sformatf("b2b bit%0d busy", k), 32'(bz[0]), 32'h1);
      chk($sformatf("b2b bit%0d done", k), 32'(dn[0]), 32'(k == 7 || k == 15));
      if (k == 7) din = 8'h0F;
    end
    din_valid = 1'b0;
    repeat (14) tick();
    // gap of two cycles on u2
    din_valid = 1'b1;
    din = 8'hFF;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      seen = dn[2];
    end
    chk("gap done seen", 32'(seen), 32'h1);
    for (int t = 0; t < 2; t++) begin
      tick();
      chk($sformatf("gap%0d u2 flags", t), {29'(0), sv[2], bz[2], rdy[2]}, 32'b010);
    end
    tick();
    chk("gap end u2 flags", {29'(0), sv[2], bz[2], rdy[2]}, 32'b001);
    tick();
    chk("gap next bit0", {30'(0), sv[2], so[2]}, 32'b11);
    din_valid = 1'b0;
    repeat (14) tick();
    // reset in the middle of a word
    din_valid = 1'b1;
    din = 8'hAA;
    tick();
    din_valid = 1'b0;
    din = 8'h55;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    model_clear();
    for (int i = 0; i < 3; i++) chk($sformatf("midrst u%0d outs", i), {27'(0), rdy[i], so[i], sv[i], bz[i], dn[i]}, 32'h0);
    repeat (2) tick();
    #2 rst = 1'b0;
    tick();
    din_valid = 1'b1;
    din = 8'h01;
    for (int k = 0; k < 8; k++) begin
      tick();
      din_valid = 1'b0;
      din = 8'h33;
      chk($sformatf("post-rst bit%0d", k), {29'(0), so[0], sv[0], dn[0]}, {29'(0), k == 0, 1'b1, k == 7});
    end
    repeat (6) tick();
    // random traffic with din toggling while busy
    for (int n = 0; n < 400; n++) begin
      din_valid = $urandom_range(0, 2) != 0;
      din = 8'($urandom);
      tick();
    end
    din_valid = 1'b0;
    repeat (12) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmit stage.
- Accepts a WIDTH-bit word over a valid/ready handshake and streams it one bit per clock on sout, with a qualifying sout_valid.
- Sits directly upstream of the team's serial shift-register stages: sout drives their serial input.
- Supports back-to-back streaming or a programmable idle gap between words.

Parameters:
- WIDTH, 8: word width in bits; legal values are WIDTH >= 2.
- LSB_FIRST, 1: 1 transmits bit 0 first; 0 transmits bit WIDTH-1 first.
- GAP, 0: idle cycles inserted after each word's last bit before the next word may be accepted; legal values are 0..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to transmit.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a data bit this cycle.
- busy  output  1  a word is being shifted out or the gap is running.
- done  output  1  one-cycle pulse coincident with the last bit of a word.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; shift register, bit counter and gap counter cleared.
  - sout=0, sout_valid=0, busy=0, done=0.
  - din_ready is forced 0 while rst=1 and is 1 in the first cycle after deassertion.
- States:
  - IDLE -> SHIFT on accept.
  - SHIFT -> GAP after the last bit if GAP>0.
  - SHIFT -> IDLE after the last bit if GAP=0 and no new accept.
  - SHIFT -> SHIFT (reload) if GAP=0 and a new word is accepted on the last bit.
  - GAP -> IDLE after GAP cycles.
- Accept: din_valid=1 and din_ready=1 at a rising edge. din is captured into the shift register and the bit counter is set to 0.
- din_ready = IDLE, or (SHIFT and bit counter = WIDTH-1 and GAP = 0). It is combinational from state and counter, gated by rst.
- Latency: the first bit appears on sout in the cycle after the accept edge. Bit k appears k+1 cycles after accept.
- sout, sout_valid, busy and done are registered outputs.
- SHIFT state, each cycle:
  - sout = current bit, sout_valid = 1, busy = 1.
  - Register shifts by one position (direction set by LSB_FIRST).
  - Bit counter increments.
- done = 1 exactly in the cycle bit WIDTH-1 is on sout; otherwise 0.
- Back-to-back (GAP=0): a word accepted during the last-bit cycle has its first bit on sout the next cycle. sout_valid stays high continuously across words. busy never drops.
- GAP state:
  - sout = 0, sout_valid = 0, busy = 1, din_ready = 0.
  - The gap counter runs for exactly GAP cycles, then the state goes to IDLE.
- IDLE: sout = 0, sout_valid = 0, busy = 0, done = 0.
- din_valid while din_ready=0 is ignored. No word is captured, and din may change freely.
- din is sampled only on the accept edge. Later changes to din do not affect the word in flight.
- Reset mid-word or mid-gap: the word is discarded immediately (asynchronously) and no done pulse is issued. After deassertion, the first word accepted is transmitted from bit 0 of the sequence.
- Counter widths are sized with $clog2 and hold WIDTH-1 and GAP without overflow. There is no wrap-around inside a word.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, GAP=0; accept din=8'hB4 at edge T -> sout = 0,0,1,0,1,1,0,1 in cycles T+1..T+8; sout_valid=1 throughout; done=1 only at T+8; busy=0 at T+9.
2. WIDTH=8, LSB_FIRST=0; accept 8'hB4 -> sout = 1,0,1,1,0,1,0,0; done at the 8th bit.
3. GAP=0; din_valid held high with 8'hF0 then 8'h0F presented on the last-bit cycle -> 16 contiguous sout_valid cycles with sout = 0,0,0,0,1,1,1,1,1,1,1,1,0,0,0,0; busy stays 1; done pulses at bits 8 and 16.
4. GAP=2; accept 8'hFF with din_valid held high -> after done, 2 cycles with sout_valid=0, busy=1, din_ready=0. The next word is accepted on the following edge, and its first bit appears 4 cycles after the first word's done.
5. Accept 8'hAA, assert rst during bit 3 -> all outputs 0 immediately and no done. After release, accept 8'h01 (LSB_FIRST=1) -> sout = 1,0,0,0,0,0,0,0 starting the cycle after accept.
6. While busy, toggle din_valid and din (8'h55 / 8'h33) -> the in-flight word is unchanged and the new values are not captured until din_ready=1.
